vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
Sequential vending controller for N drinks with per-drink prices set by parameters. It accumulates coins into a credit register and accepts a drink selection. It then runs a dispense handshake followed by a change-return handshake. It is the clocked successor to the combinational bill calculator, and sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

Parameters:
CASH_W, 7, width of coin, credit, price and change values
N_DRINKS, 2, number of selectable drinks, must be >= 2
SEL_W, 1, width of sel_id/dispense_id; must satisfy 2^SEL_W >= N_DRINKS
PRICES, {7'd35,7'd50}, packed price table; drink i price = PRICES[i*CASH_W +: CASH_W]; default drink 0 (coffee) = 50, drink 1 (tea) = 35
TIMEOUT_CYC, 1024, inactivity cycles before auto-refund (used only with VEND_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
coin_valid  input  1  coin present this cycle
coin_val  input  CASH_W  coin value
sel_valid  input  1  drink selection request, single-cycle
sel_id  input  SEL_W  selected drink index
cancel  input  1  refund request
dispense_valid  output  1  drink dispense request
dispense_id  output  SEL_W  drink to dispense
dispense_ready  input  1  dispenser accepts
change_valid  output  1  change return request
change_amt  output  CASH_W  change value
change_ready  input  1  hopper accepts
credit  output  CASH_W  current credit, registered
cash_low  output  1  one-cycle pulse: selection refused for insufficient credit
coin_reject  output  1  one-cycle pulse: coin not accepted
busy  output  1  high in VEND or CHANGE
timeout  output  1  one-cycle pulse on auto-refund (tied 0 without macro)

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, credit=0, every output 0, dispense_id=0, change_amt=0, timeout counter=0. Reset mid-VEND or mid-CHANGE aborts the transaction; credit is lost.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, CHANGE. All outputs are registered; each response appears the cycle after the causing input.
- Per-cycle priority in IDLE/COLLECT: cancel > sel_valid > coin_valid.
- Coin handling:
  - coin_valid alone: credit += coin_val.
  - If credit+coin_val > 2^CASH_W-1 (computed CASH_W+1 bits wide): coin_reject pulse, credit unchanged.
  - coin_valid coinciding with cancel or sel_valid, or arriving in VEND/CHANGE: coin_reject pulse, coin ignored.
  - coin_val==0: accepted, no effect.
  - IDLE->COLLECT when credit becomes nonzero.
- Selection handling:
  - sel_id >= N_DRINKS: ignored silently.
  - credit >= price: latch dispense_id=sel_id, credit -= price, go VEND.
  - Otherwise: cash_low pulse, credit and state unchanged.
  - Exact price leaves credit 0.
- Cancel:
  - COLLECT: go CHANGE with change_amt=credit.
  - IDLE: ignored.
- VEND:
  - dispense_valid=1, dispense_id stable until the cycle dispense_ready=1.
  - On handshake: dispense_valid=0; if credit>0 go CHANGE (change_amt=credit), else IDLE.
  - sel_valid and cancel are ignored in VEND.
- CHANGE:
  - change_valid=1, change_amt stable until change_ready=1.
  - On handshake: credit=0, change_valid=0, go IDLE.
  - sel_valid and cancel are ignored in CHANGE.
- ready may be held high continuously; minimum VEND and CHANGE occupancy is one cycle each.
- busy = (state==VEND || state==CHANGE).

Optional Feature:
Macro VEND_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYC)+1 runs in COLLECT.
  - It clears on any accepted coin, cash_low event, or exit from COLLECT.
  - When it reaches TIMEOUT_CYC-1 with no other event that cycle: go CHANGE with change_amt=credit and pulse timeout for one cycle.
  - Events in that same cycle take priority and clear the counter.
- Not defined: no counter is built, timeout is tied 0, and credit is held indefinitely.

Test Plan:
- Reset, then coins 20,20,20 (credit 60), sel_id=0 -> dispense_valid, dispense_id=0; after dispense_ready, change_valid with change_amt=10; after change_ready, credit=0, state IDLE.
- Coins 25,10, sel_id=1 -> dispense id 1; no change_valid; busy drops after handshake; credit=0.
- Coin 30, sel_id=0 -> cash_low pulse, credit stays 30; cancel -> change_amt=30; change_ready -> IDLE.
- credit 120 + coin 10 -> coin_reject, credit 120; coin and sel_valid in the same cycle -> coin_reject, selection evaluated on the old credit.
- Hold dispense_ready=0 for 5 cycles in VEND while toggling coin/sel/cancel -> dispense_id stable, coin_reject on each coin, no state change; assert rst_n=0 mid-VEND -> all outputs 0 asynchronously.
- With VEND_TIMEOUT_EN and TIMEOUT_CYC=16: coin 15, then idle 16 cycles -> timeout pulse, change_amt=15; a coin at cycle 10 restarts the count.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, priced selection, dispense and change handshakes.
// Define VEND_TIMEOUT_EN to auto-refund credit after TIMEOUT_CYC idle cycles.
module vend_ctrl #(
  parameter int CASH_W = 7,
  parameter int N_DRINKS = 2,
  parameter int SEL_W = 1,
  parameter logic [N_DRINKS*CASH_W-1:0] PRICES = {7'd35, 7'd50},
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_valid,
  input  logic [CASH_W-1:0] coin_val,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel_id,
  input  logic              cancel,
  output logic              dispense_valid,
  output logic [SEL_W-1:0]  dispense_id,
  input  logic              dispense_ready,
  output logic              change_valid,
  output logic [CASH_W-1:0] change_amt,
  input  logic              change_ready,
  output logic [CASH_W-1:0] credit,
  output logic              cash_low,
  output logic              coin_reject,
  output logic              busy,
  output logic              timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] VEND    = 2'd2;
  localparam logic [1:0] CHANGE  = 2'd3;

  if (N_DRINKS < 2) begin : g_bad_n
    $error("N_DRINKS must be >= 2");
  end
  if ((1 << SEL_W) < N_DRINKS) begin : g_bad_sel
    $error("SEL_W too narrow for N_DRINKS");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_to
    $error("TIMEOUT_CYC must be >= 2");
  end

  logic [1:0]        state, state_d;
  logic [CASH_W-1:0] credit_d, change_amt_d, price;
  logic [SEL_W-1:0]  dispense_id_d;
  logic              dispense_valid_d, change_valid_d;
  logic              cash_low_d, coin_reject_d;
  logic              sel_ok, coin_ok, coin_acc;
  logic [CASH_W:0]   coin_sum;

`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             timeout_d;
`endif

  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_DRINKS; i++) begin
      if (sel_id == SEL_W'(i)) begin
        price  = PRICES[i*CASH_W +: CASH_W];
        sel_ok = 1'b1;
      end
    end
  end

  // Overflow is judged one bit wider than the credit register
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_ok  = !coin_sum[CASH_W];

  always_comb begin
    state_d          = state;
    credit_d         = credit;
    change_amt_d     = change_amt;
    dispense_id_d    = dispense_id;
    dispense_valid_d = dispense_valid;
    change_valid_d   = change_valid;
    cash_low_d       = 1'b0;
    coin_reject_d    = 1'b0;
    coin_acc         = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        coin_reject_d = coin_valid & (cancel | sel_valid | !coin_ok);
        if (cancel) begin
          if (state == COLLECT) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit;
          end
        end else if (sel_valid) begin
          if (sel_ok && credit >= price) begin
            state_d          = VEND;
            dispense_valid_d = 1'b1;
            dispense_id_d    = sel_id;
            credit_d         = credit - price;
          end else if (sel_ok) begin
            cash_low_d = 1'b1;
          end
        end else if (coin_valid && coin_ok) begin
          coin_acc = 1'b1;
          credit_d = coin_sum[CASH_W-1:0];
          if (credit_d != '0) state_d = COLLECT;
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        if (dispense_ready) begin
          dispense_valid_d = 1'b0;
          if (credit != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ready) begin
          state_d        = IDLE;
          credit_d       = '0;
          change_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef VEND_TIMEOUT_EN
    timeout_d = 1'b0;
    cnt_d     = '0;
    if (state == COLLECT && state_d == COLLECT && !coin_acc && !cash_low_d) begin
      if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d        = CHANGE;
        change_valid_d = 1'b1;
        change_amt_d   = credit;
        timeout_d      = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      credit         <= '0;
      change_amt     <= '0;
      dispense_id    <= '0;
      dispense_valid <= 1'b0;
      change_valid   <= 1'b0;
      cash_low       <= 1'b0;
      coin_reject    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      credit         <= credit_d;
      change_amt     <= change_amt_d;
      dispense_id    <= dispense_id_d;
      dispense_valid <= dispense_valid_d;
      change_valid   <= change_valid_d;
      cash_low       <= cash_low_d;
      coin_reject    <= coin_reject_d;
      busy           <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
